// File: rtl/cpu_trap_ctrl_pkg.sv
// Shared definitions for the trap controller: state encodings, mtvec modes
// and the machine interrupt cause codes.
package cpu_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        TRAPST_IDLE  = 2'd0,
        TRAPST_DRAIN = 2'd1,
        TRAPST_ACK   = 2'd2
    } trap_state_e;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

    localparam logic [3:0] INT_CODE_MSI = 4'd3;
    localparam logic [3:0] INT_CODE_MTI = 4'd7;
    localparam logic [3:0] INT_CODE_MEI = 4'd11;

    // Reserved modes 2 and 3 fall back to direct.
    function automatic logic is_vectored(input logic [1:0] mode);
        return mode == MTVEC_MODE_VECTORED;
    endfunction

endpackage

// File: rtl/cpu_trap_vector.sv
// Trap target computation: mtvec base, plus cause*4 for vectored interrupts.
module cpu_trap_vector
    import cpu_trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [3:0]      i_int_code,
    input  logic            i_is_interrupt,
    output logic [XLEN-1:0] o_target
);

    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_offset;

    assign w_base   = {i_mtvec[XLEN-1:2], 2'b00};
    assign w_offset = {{(XLEN-6){1'b0}}, i_int_code, 2'b00};

    // Exceptions always land on the base even when mtvec is vectored.
    assign o_target = (i_is_interrupt && is_vectored(i_mtvec[1:0])) ? w_base + w_offset
                                                                     : w_base;

endmodule

// File: rtl/cpu_trap_ctrl.sv
// Trap entry/exit sequencer: drains memory traffic before acknowledging an
// interrupt, and redirects fetch for exceptions, MRET and interrupt entry.
module cpu_trap_ctrl
    import cpu_trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            int_req,
    input  logic [3:0]      int_code,
    output logic            int_ack,
    input  logic            exception_w,
    input  logic            mret_w,
    input  logic            mem_busy,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            stall_f,
    output logic            flush_fde,
    output logic            flush_m,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    trap_state_e     r_state;
    trap_state_e     w_next;
    logic [XLEN-1:0] w_vec_pc;
    logic            w_is_int;

    assign w_is_int = (r_state == TRAPST_ACK) && !exception_w;

    cpu_trap_vector #(.XLEN(XLEN)) u_vec (
        .i_mtvec        (mtvec),
        .i_int_code     (int_code),
        .i_is_interrupt (w_is_int),
        .o_target       (w_vec_pc)
    );

    always_comb begin
        w_next      = r_state;
        int_ack     = 1'b0;
        stall_f     = 1'b0;
        flush_fde   = 1'b0;
        flush_m     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        busy        = (r_state != TRAPST_IDLE);

        if (exception_w || mret_w) begin
            // W-stage events pre-empt any interrupt entry in flight.
            flush_fde   = 1'b1;
            flush_m     = 1'b1;
            redirect    = 1'b1;
            redirect_pc = exception_w ? w_vec_pc : mepc;
            w_next      = TRAPST_IDLE;
        end else begin
            unique case (r_state)
                TRAPST_IDLE: begin
                    if (int_req) w_next = TRAPST_DRAIN;
                end
                TRAPST_DRAIN: begin
                    stall_f = 1'b1;
                    if (!int_req)      w_next = TRAPST_IDLE;
                    else if (!mem_busy) w_next = TRAPST_ACK;
                end
                TRAPST_ACK: begin
                    // M stage is allowed to retire; only F/D/E are squashed.
                    w_next = TRAPST_IDLE;
                    if (int_req) begin
                        int_ack     = 1'b1;
                        flush_fde   = 1'b1;
                        redirect    = 1'b1;
                        redirect_pc = w_vec_pc;
                    end
                end
                default: w_next = TRAPST_IDLE;
            endcase
        end

        if (rst) begin
            w_next      = TRAPST_IDLE;
            int_ack     = 1'b0;
            stall_f     = 1'b0;
            flush_fde   = 1'b0;
            flush_m     = 1'b0;
            redirect    = 1'b0;
            redirect_pc = '0;
            busy        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= TRAPST_IDLE;
        else     r_state <= w_next;
    end

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// Self-checking bench for cpu_trap_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_cpu_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst, int_req, exception_w, mret_w, mem_busy;
    logic [3:0]  int_code;
    logic [31:0] mtvec, mepc;
    logic        int_ack, stall_f, flush_fde, flush_m, redirect, busy;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;

    // Model: a request has been seen and is waiting for memory to settle,
    // or entry is due this cycle.
    bit m_waiting, m_entering;

    cpu_trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .int_req(int_req), .int_code(int_code),
        .int_ack(int_ack), .exception_w(exception_w), .mret_w(mret_w),
        .mem_busy(mem_busy), .mtvec(mtvec), .mepc(mepc), .stall_f(stall_f),
        .flush_fde(flush_fde), .flush_m(flush_m), .redirect(redirect),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] e_pc, base;
        logic e_ack, e_stall, e_ff, e_fm, e_rd, e_busy;
        base = {mtvec[31:2], 2'b00};
        e_pc = 0; e_ack = 0; e_stall = 0; e_ff = 0; e_fm = 0; e_rd = 0; e_busy = 0;
        if (!rst) begin
            e_busy = m_waiting || m_entering;
            if (exception_w) begin
                e_ff = 1; e_fm = 1; e_rd = 1; e_pc = base;
            end else if (mret_w) begin
                e_ff = 1; e_fm = 1; e_rd = 1; e_pc = mepc;
            end else begin
                e_stall = m_waiting;
                if (m_entering && int_req) begin
                    e_ack = 1; e_ff = 1; e_rd = 1;
                    e_pc = (mtvec[1:0] == 2'd1) ? base + 32'(int_code) * 4 : base;
                end
            end
        end
        chk("int_ack", 32'(int_ack), 32'(e_ack));
        chk("stall_f", 32'(stall_f), 32'(e_stall));
        chk("flush_fde", 32'(flush_fde), 32'(e_ff));
        chk("flush_m", 32'(flush_m), 32'(e_fm));
        chk("redirect", 32'(redirect), 32'(e_rd));
        chk("redirect_pc", redirect_pc, e_pc);
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic model_step();
        if (rst || exception_w || mret_w) begin
            m_waiting = 0; m_entering = 0;
        end else if (m_entering) begin
            m_entering = 0;
        end else if (m_waiting) begin
            if (!int_req)       m_waiting = 0;
            else if (!mem_busy) begin m_waiting = 0; m_entering = 1; end
        end else if (int_req) begin
            m_waiting = 1;
        end
    endtask

    // Sample half a cycle after inputs settle, then commit the edge.
    task automatic at_neg();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        int_req = 0; exception_w = 0; mret_w = 0; mem_busy = 0;
    endtask

    initial begin
        rst = 1; int_code = 4'd7; mtvec = 32'h1000; mepc = 0;
        idle_inputs();
        m_waiting = 0; m_entering = 0;

        // Reset: outputs quiet
        at_neg();
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        advance();
        rst = 0;
        for (int i = 0; i < 9; i++) begin at_neg(); advance(); end

        // Direct interrupt: rise at N, ack at N+2, idle at N+3
        int_req = 1; int_code = 4'd7; mtvec = 32'h0000_1000;
        at_neg(); chk("d_first_ack", 32'(int_ack), 0); chk("d_first_busy", 32'(busy), 0); advance();
        at_neg(); chk("d_drain_stall", 32'(stall_f), 1); advance();
        at_neg();
        chk("d_ack", 32'(int_ack), 1); chk("d_flush_fde", 32'(flush_fde), 1);
        chk("d_flush_m", 32'(flush_m), 0); chk("d_pc", redirect_pc, 32'h1000);
        advance();
        int_req = 0;
        at_neg(); chk("d_idle", 32'(busy), 0); advance();

        // Vectored interrupt held off by memory traffic
        int_req = 1; int_code = 4'd11; mtvec = 32'h0000_2001; mem_busy = 1;
        at_neg(); advance();
        for (int c = 11; c <= 14; c++) begin
            if (c == 14) mem_busy = 0;
            at_neg(); chk("v_stall", 32'(stall_f), 1); chk("v_noack", 32'(int_ack), 0); advance();
        end
        at_neg(); chk("v_ack", 32'(int_ack), 1); chk("v_pc", redirect_pc, 32'h202C); advance();
        int_req = 0;
        at_neg(); advance();

        // Exception beats an interrupt in DRAIN
        int_req = 1; mem_busy = 1;
        at_neg(); advance();
        at_neg(); chk("e_in_drain", 32'(busy), 1); advance();
        exception_w = 1;
        at_neg();
        chk("e_pc", redirect_pc, 32'h2000); chk("e_flush_m", 32'(flush_m), 1);
        chk("e_flush_fde", 32'(flush_fde), 1); chk("e_noack", 32'(int_ack), 0);
        chk("e_nostall", 32'(stall_f), 0);
        advance();
        exception_w = 0; int_req = 0;
        at_neg(); chk("e_idle", 32'(busy), 0); advance();

        // MRET
        mret_w = 1; mepc = 32'h0000_0480;
        at_neg();
        chk("m_redirect", 32'(redirect), 1); chk("m_pc", redirect_pc, 32'h480);
        chk("m_flush_m", 32'(flush_m), 1); chk("m_busy", 32'(busy), 0);
        advance();
        mret_w = 0;
        at_neg(); advance();

        // Request withdrawn during DRAIN
        int_req = 1; mem_busy = 1;
        at_neg(); advance();
        at_neg(); advance();
        at_neg(); advance();
        int_req = 0;
        at_neg(); chk("w_noredirect", 32'(redirect), 0); advance();
        at_neg(); chk("w_idle", 32'(busy), 0); chk("w_noack", 32'(int_ack), 0); advance();

        // Reset while in DRAIN, then a normal 2-cycle entry
        int_req = 1; mem_busy = 1; mtvec = 32'h0000_1000; int_code = 4'd3;
        at_neg(); advance();
        at_neg(); advance();
        rst = 1;
        at_neg(); chk("r_quiet_stall", 32'(stall_f), 0); advance();
        rst = 0; int_req = 0; mem_busy = 0;
        at_neg(); chk("r_idle", 32'(busy), 0); advance();
        int_req = 1;
        at_neg(); advance();
        at_neg(); advance();
        at_neg(); chk("r_ack", 32'(int_ack), 1); chk("r_pc", redirect_pc, 32'h1000); advance();
        int_req = 0;
        at_neg(); advance();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] pick;
            rst         = ($urandom_range(63) == 0);
            if ($urandom_range(5) == 0) int_req = ~int_req;
            pick        = 2'($urandom_range(2));
            int_code    = (pick == 0) ? 4'd3 : (pick == 1) ? 4'd7 : 4'd11;
            exception_w = ($urandom_range(15) == 0);
            mret_w      = ($urandom_range(15) == 0);
            mem_busy    = ($urandom_range(2) != 0);
            mtvec       = $urandom;
            mepc        = $urandom;
            at_neg();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
